// File: rtl/seven_segment_scan.sv
// Time-multiplexed common-anode seven-segment driver with dwell prescaler, leading-zero blanking,
// sticky error display and optional PWM dimming (enabled by defining SEVSEG_DIM_EN).
module seven_segment_scan #(
    parameter  int N_DIGITS = 8,
    parameter  int DIV      = 1,
    parameter  int BRIGHT_W = 16,
    localparam int POS_W    = $clog2(N_DIGITS)
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic                  CE,
    input  logic [4*N_DIGITS-1:0] NUMBER,
    input  logic [N_DIGITS-1:0]   DP,
    input  logic [N_DIGITS-1:0]   AN_MASK,
    input  logic                  BLANK_LZ,
    input  logic                  error_in,
`ifdef SEVSEG_DIM_EN
    input  logic [BRIGHT_W-1:0]   BRIGHT,
`endif
    output logic [N_DIGITS-1:0]   AN,
    output logic [7:0]            SEG,
    output logic [POS_W-1:0]      DIGIT_POS
);

    localparam int               PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_DIGITS - 1);
    localparam logic [7:0]       SEG_ERR  = 8'h86;

    logic [PRE_W-1:0]    pre;
    logic [POS_W-1:0]    pos;
    logic                err;
    logic                gate_open;
    logic [N_DIGITS-1:0] lz_blank;
    logic [N_DIGITS-1:0] an_next;
    logic [7:0]          seg_next;

    function automatic logic [6:0] hex_font(input logic [3:0] d);
        case (d)
            4'h0: hex_font = 7'h40;
            4'h1: hex_font = 7'h79;
            4'h2: hex_font = 7'h24;
            4'h3: hex_font = 7'h30;
            4'h4: hex_font = 7'h19;
            4'h5: hex_font = 7'h12;
            4'h6: hex_font = 7'h02;
            4'h7: hex_font = 7'h78;
            4'h8: hex_font = 7'h00;
            4'h9: hex_font = 7'h10;
            4'hA: hex_font = 7'h08;
            4'hB: hex_font = 7'h03;
            4'hC: hex_font = 7'h46;
            4'hD: hex_font = 7'h21;
            4'hE: hex_font = 7'h06;
            default: hex_font = 7'h0E;
        endcase
    endfunction

    // Dwell prescaler and scan position; both freeze while CE is low.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (RESET) begin
            pre <= '0;
            pos <= '0;
        end else if (CE) begin
            if (pre == PRE_LAST) begin
                pre <= '0;
                pos <= (pos == POS_LAST) ? '0 : pos + POS_W'(1);
            end else begin
                pre <= pre + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            err <= 1'b0;
        end else if (error_in) begin
            err <= 1'b1;
        end
    end

`ifdef SEVSEG_DIM_EN
    localparam int CMP_W = (PRE_W > BRIGHT_W) ? PRE_W : BRIGHT_W;

    logic [BRIGHT_W-1:0] duty_q;
    logic [BRIGHT_W-1:0] duty_eff;

    always_ff @(posedge clk) begin
        if (RESET) begin
            duty_q <= '0;
        end else if (pre == '0) begin
            duty_q <= BRIGHT;
        end
    end

    // The first cycle of a slot already uses the value being latched, so a slot never sees two duties.
    assign duty_eff  = (pre == '0) ? BRIGHT : duty_q;
    assign gate_open = CMP_W'(pre) < CMP_W'(duty_eff);
`else
    assign gate_open = 1'b1;
`endif

    // lz_blank[i]: nibbles i..N_DIGITS-1 are all zero; digit 0 is always shown.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_above  = zero_above && (NUMBER[4*i +: 4] == 4'h0);
            lz_blank[i] = zero_above && (i != 0);
        end
    end

    // NOTE: both outputs get a default first so no path through this block can infer a latch.
    always_comb begin
        logic blanked;
        an_next  = '1;
        seg_next = err ? SEG_ERR : {~DP[pos], hex_font(NUMBER[{pos, 2'b00} +: 4])};
        blanked  = BLANK_LZ && lz_blank[pos] && !err;
        if (!AN_MASK[pos] && !blanked && gate_open) begin
            an_next[pos] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            AN  <= '1;
            SEG <= 8'hFF;
        end else begin
            AN  <= an_next;
            SEG <= seg_next;
        end
    end

    assign DIGIT_POS = pos;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan: a DIV=1 and a DIV=4 instance driven side by side, checked against
// directed constants and a count-based reference model.
module tb_seven_segment_scan;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] ce  = 2'b00;
    logic [31:0] number = '0;
    logic [7:0] dp = '0;
    logic [7:0] an_mask = '0;
    logic       blank_lz = 1'b0;
    logic       error_in = 1'b0;
`ifdef SEVSEG_DIM_EN
    logic [15:0] bright = 16'd1;
`endif

    logic [7:0] an_o  [2];
    logic [7:0] seg_o [2];
    logic [2:0] pos_o [2];

    int errors = 0;
    int checks = 0;

    logic [7:0] font     [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [7:0] scan_seg [8]  = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

    always #5 clk = ~clk;

    seven_segment_scan #(.N_DIGITS(8), .DIV(1)) u_div1 (
        .clk(clk), .RESET(rst), .CE(ce[0]), .NUMBER(number), .DP(dp), .AN_MASK(an_mask),
        .BLANK_LZ(blank_lz), .error_in(error_in),
`ifdef SEVSEG_DIM_EN
        .BRIGHT(bright),
`endif
        .AN(an_o[0]), .SEG(seg_o[0]), .DIGIT_POS(pos_o[0])
    );

    seven_segment_scan #(.N_DIGITS(8), .DIV(4)) u_div4 (
        .clk(clk), .RESET(rst), .CE(ce[1]), .NUMBER(number), .DP(dp), .AN_MASK(an_mask),
        .BLANK_LZ(blank_lz), .error_in(error_in),
`ifdef SEVSEG_DIM_EN
        .BRIGHT(bright),
`endif
        .AN(an_o[1]), .SEG(seg_o[1]), .DIGIT_POS(pos_o[1])
    );

    // Reference model: position and prescale phase follow from the number of CE cycles since reset.
    int         cnt    [2];
    bit         err_m  [2];
    logic [7:0] exp_an [2];
    logic [7:0] exp_seg[2];
    logic [2:0] exp_pos[2];
`ifdef SEVSEG_DIM_EN
    logic [15:0] duty_m[2];
`endif

    function automatic int div_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                exp_an[k]  = 8'hFF;
                exp_seg[k] = 8'hFF;
                cnt[k]     = 0;
                err_m[k]   = 1'b0;
`ifdef SEVSEG_DIM_EN
                duty_m[k]  = '0;
`endif
            end else begin
                int p;
                int pr;
                logic [7:0] f;
                bit blank;
                bit gate;
                p  = (cnt[k] / div_of(k)) % N;
                pr = cnt[k] % div_of(k);
                f  = font[number[4*p +: 4]];
                exp_seg[k] = err_m[k] ? 8'h86 : {~dp[p], f[6:0]};
                blank = blank_lz && (p > 0) && ((number >> (4*p)) == 32'd0) && !err_m[k];
`ifdef SEVSEG_DIM_EN
                if (pr == 0) duty_m[k] = bright;
                gate = pr < int'(duty_m[k]);
`else
                gate = 1'b1;
`endif
                exp_an[k] = 8'hFF;
                if (!an_mask[p] && !blank && gate) exp_an[k][p] = 1'b0;
                cnt[k]   = cnt[k] + int'(ce[k]);
                err_m[k] = err_m[k] | error_in;
            end
            exp_pos[k] = 3'((cnt[k] / div_of(k)) % N);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ce  = 2'b11;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (an_o[k] !== 8'hFF || seg_o[k] !== 8'hFF || pos_o[k] !== 3'd0) begin
                errors++;
                $display("FAIL reset[%0d]: an=%h seg=%h pos=%0d, expected an=ff seg=ff pos=0",
                         k, an_o[k], seg_o[k], pos_o[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        number = 32'h76543210; dp = '0; an_mask = '0; blank_lz = 1'b0; error_in = 1'b0; ce = 2'b11;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            logic [7:0] want_an;
            @(negedge clk);
            want_an = ~(8'h01 << (i % 8));
            checks++;
            if (an_o[0] !== want_an || seg_o[0] !== scan_seg[i % 8] || pos_o[0] !== 3'((i + 1) % 8)) begin
                errors++;
                $display("FAIL scan slot %0d: an=%h seg=%h pos=%0d, expected an=%h seg=%h pos=%0d",
                         i, an_o[0], seg_o[0], pos_o[0], want_an, scan_seg[i % 8], (i + 1) % 8);
            end
        end
    endtask

    task automatic test_mask();
        number = 32'h76543210; an_mask = 8'b0010_1100; ce = 2'b11;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            logic [7:0] want_an;
            @(negedge clk);
            want_an = ~(8'h01 << i) | 8'h2C;
            checks++;
            if (an_o[0] !== want_an || seg_o[0] !== scan_seg[i]) begin
                errors++;
                $display("FAIL mask slot %0d: an=%h seg=%h, expected an=%h seg=%h",
                         i, an_o[0], seg_o[0], want_an, scan_seg[i]);
            end
        end
        an_mask = '0;
    endtask

    task automatic test_blank();
        number = 32'h00000A00; blank_lz = 1'b1; dp = 8'h04; an_mask = '0; ce = 2'b11;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            logic [7:0] want_an;
            logic [7:0] want_seg;
            @(negedge clk);
            want_an  = (i < 3) ? ~(8'h01 << i) : 8'hFF;
            want_seg = (i == 2) ? 8'h08 : 8'hC0;
            checks++;
            if (an_o[0] !== want_an || seg_o[0] !== want_seg) begin
                errors++;
                $display("FAIL blank slot %0d: an=%h seg=%h, expected an=%h seg=%h",
                         i, an_o[0], seg_o[0], want_an, want_seg);
            end
        end
        blank_lz = 1'b0; dp = '0;
    endtask

    task automatic test_error();
        number = 32'h76543210; ce = 2'b11;
        do_reset();
        repeat (3) @(negedge clk);
        error_in = 1'b1;
        @(negedge clk);
        error_in = 1'b0;
        checks++;
        if (seg_o[0] !== scan_seg[3]) begin
            errors++;
            $display("FAIL error first edge: seg=%h, expected %h", seg_o[0], scan_seg[3]);
        end
        for (int j = 0; j < 10; j++) begin
            logic [7:0] want_an;
            @(negedge clk);
            want_an = ~(8'h01 << ((4 + j) % 8));
            checks++;
            if (seg_o[0] !== 8'h86 || an_o[0] !== want_an) begin
                errors++;
                $display("FAIL error sticky %0d: an=%h seg=%h, expected an=%h seg=86",
                         j, an_o[0], seg_o[0], want_an);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (seg_o[0] !== 8'hFF || an_o[0] !== 8'hFF || pos_o[0] !== 3'd0) begin
            errors++;
            $display("FAIL error clear: an=%h seg=%h pos=%0d, expected an=ff seg=ff pos=0",
                     an_o[0], seg_o[0], pos_o[0]);
        end
        rst = 1'b0;
    endtask

    task automatic test_prescale();
        int  j;
        bit  hit;
        number = 32'h76543210; ce = 2'b00;
        do_reset();
        j   = 0;
        hit = 1'b0;
        while (!hit && j < 100) begin
            ce = {2{(j % 2) == 0}};
            @(negedge clk);
            j++;
            checks++;
            if (pos_o[1] !== 3'((((j + 1) / 2) / 4) % 8)) begin
                errors++;
                $display("FAIL prescale edge %0d: pos=%0d, expected %0d", j, pos_o[1], (((j + 1) / 2) / 4) % 8);
            end
            hit = (pos_o[1] == 3'd5);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL prescale timeout: pos=%0d, expected 5 within 100 clocks", pos_o[1]);
        end
        rst = 1'b1;
        ce  = 2'b00;
        @(negedge clk);
        checks++;
        if (pos_o[1] !== 3'd0 || an_o[1] !== 8'hFF) begin
            errors++;
            $display("FAIL prescale reset: pos=%0d an=%h, expected pos=0 an=ff", pos_o[1], an_o[1]);
        end
        rst = 1'b0;
        ce  = 2'b11;
        @(negedge clk);
        checks++;
        if (an_o[1] !== 8'hFE || seg_o[1] !== 8'hC0) begin
            errors++;
            $display("FAIL prescale restart: an=%h seg=%h, expected an=fe seg=c0", an_o[1], seg_o[1]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(0, 99) == 0);
            ce       = 2'($urandom);
            number   = $urandom >> (4 * $urandom_range(0, 8));
            dp       = 8'($urandom);
            an_mask  = 8'($urandom) & 8'($urandom);
            blank_lz = 1'($urandom);
            error_in = ($urandom_range(0, 199) == 0);
`ifdef SEVSEG_DIM_EN
            bright   = 16'($urandom_range(0, 5));
`endif
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (an_o[k] !== exp_an[k] || seg_o[k] !== exp_seg[k] || pos_o[k] !== exp_pos[k]) begin
                    errors++;
                    $display("FAIL random[%0d] cycle %0d: an=%h seg=%h pos=%0d, expected an=%h seg=%h pos=%0d",
                             k, c, an_o[k], seg_o[k], pos_o[k], exp_an[k], exp_seg[k], exp_pos[k]);
                end
            end
        end
        rst = 1'b0; error_in = 1'b0; an_mask = '0; blank_lz = 1'b0; dp = '0;
    endtask

`ifdef SEVSEG_DIM_EN
    task automatic test_dim();
        int duty_tab [3] = '{2, 0, 9};
        int want_tab [3] = '{16, 0, 32};
        number = 32'h76543210; an_mask = '0; blank_lz = 1'b0; ce = 2'b11;
        for (int t = 0; t < 3; t++) begin
            int lit;
            bright = 16'(duty_tab[t]);
            do_reset();
            lit = 0;
            for (int c = 0; c < 32; c++) begin
                @(negedge clk);
                if (an_o[1] != 8'hFF) lit++;
            end
            checks++;
            if (lit !== want_tab[t]) begin
                errors++;
                $display("FAIL dim bright=%0d: lit cycles=%0d, expected %0d", duty_tab[t], lit, want_tab[t]);
            end
        end
        bright = 16'd1;
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_mask();
        test_blank();
        test_error();
        test_prescale();
`ifdef SEVSEG_DIM_EN
        test_dim();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_segment_scan.md
# seven_segment_scan

Parametrised time-multiplexed driver for common-anode seven-segment displays, the next generation of the team's `seven_segment_led` driver. It scans `N_DIGITS` hex digits from a packed `NUMBER` bus onto active-low anode and cathode lines. It adds a programmable per-digit dwell time, per-digit decimal points, leading-zero blanking, a sticky error display and optional PWM dimming. It sits between the system register file and the board's display pins.

## Interface
- `N_DIGITS`, 8: number of digits scanned; legal range 2..16.
- `DIV`, 1: CE-qualified clock cycles each digit stays selected; legal range 1..65535.
- `BRIGHT_W`, 16: width of `BRIGHT`; must satisfy 2^`BRIGHT_W` > `DIV`.
- `POS_W`, $clog2(`N_DIGITS`): width of `DIGIT_POS` (derived, not overridden).

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `CE` in 1: scan enable; advances the prescaler and scan position.
- `NUMBER` in 4*`N_DIGITS`: digit i = `NUMBER[4i+3:4i]`.
- `DP` in `N_DIGITS`: 1 lights the decimal point of digit i.
- `AN_MASK` in `N_DIGITS`: 1 forces the anode of digit i off.
- `BLANK_LZ` in 1: 1 enables leading-zero blanking.
- `error_in` in 1: sets the sticky error latch.
- `BRIGHT` in `BRIGHT_W`: dimming duty; present only with `SEVSEG_DIM_EN`.
- `AN` out `N_DIGITS`: active-low anodes, registered.
- `SEG` out 8: active-low cathodes `{dp,g,f,e,d,c,b,a}`, registered.
- `DIGIT_POS` out `POS_W`: current scan position.

## Operation
- Prescaler `pre` counts CE cycles from 0 to DIV-1.
  - On CE with `pre`==DIV-1: `pre`→0 and `DIGIT_POS` increments, wrapping from N_DIGITS-1 to 0.
  - CE low: `pre` and `DIGIT_POS` hold.
- Hex decode, bits[6:0]:
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8
  - 8 80, 9 90, A 88, B 83, C C6, D A1, E 86, F 8E
- `SEG[7]` = ~`DP[DIGIT_POS]`.
- Error latch `err` is set when `error_in`=1 and cleared only by RESET.
  - While `err`=1, `SEG` = 8'h86 ("E", dp off) for every digit; anode scanning continues unchanged.
- Leading-zero blanking: digit i>0 is blanked when `BLANK_LZ`=1 and nibbles i..N_DIGITS-1 are all zero. Digit 0 is never blanked. Blanking is ignored while `err`=1.
- Anode of position p is active (0) only when all of these hold:
  - p == `DIGIT_POS`
  - `AN_MASK[p]`=0
  - digit p is not blanked
  - the dimming gate is open
- All other anodes are 1. Masked or blanked slots are still visited for their full dwell; scanning never skips a slot.

## Timing
- Reset values: `AN`=all 1, `SEG`=8'hFF, `DIGIT_POS`=0, `pre`=0, `err`=0, dimming duty latch=0.
- `AN` and `SEG` are registered from the current-cycle `DIGIT_POS`, `NUMBER`, `DP`, `AN_MASK`, `BLANK_LZ`, `err` and gate.
  - Latency is 1 clock from any input change to the output.
  - Latency is 1 clock from a `DIGIT_POS` change to the matching `AN`/`SEG`.
- `error_in` pulse at edge k: `err`=1 after edge k; `SEG`=8'h86 after edge k+1.
- RESET asserted mid-scan: every state returns to its reset value at the next edge, regardless of CE. The first active anode after release is digit 0.
- `DIV`=1 with CE held high: a new digit every clock, giving a full frame every `N_DIGITS` clocks.

## Configuration
- `SEVSEG_DIM_EN` defined:
  - `BRIGHT` port exists.
  - `BRIGHT` is latched into the duty register whenever `pre`==0.
  - The gate is open while `pre` < duty.
  - duty=0: all anodes off.
  - duty ≥ `DIV`: full brightness.
  - A `BRIGHT` change takes effect at the next digit slot, never mid-slot.
- `SEVSEG_DIM_EN` undefined: no `BRIGHT` port, no duty register, and the gate is always open.

## Test plan
- N=8, DIV=1, CE=1, `NUMBER`=32'h76543210, masks 0: after reset release, successive cycles give `AN`=FE,FD,FB,…,7F with `SEG`=C0,F9,A4,B0,99,92,82,F8; `AN` returns to FE after the 8th digit.
- Same setup, `AN_MASK`=8'b00101100: `AN` per slot = (one-hot-low | 2C); `SEG` still shows digits 2, 3 and 5 in their slots.
- `NUMBER`=32'h00000A00, `BLANK_LZ`=1: `AN` stays all 1 in slots 3..7; slots 0..2 active with `SEG`=C0,C0,88; `DP`=8'h04 gives `SEG`=08 in slot 2.
- One-cycle `error_in` pulse mid-frame: `SEG`=86 from the 2nd edge onward and it persists after `error_in` falls; RESET restores `SEG`=FF and `DIGIT_POS`=0.
- DIV=4, CE toggled 1/0 every clock: `DIGIT_POS` advances every 8 clocks; RESET while `DIGIT_POS`=5 returns it to 0 on the next edge.
- `SEVSEG_DIM_EN`, DIV=4: `BRIGHT`=2 gives each anode low for 2 of 4 cycles; `BRIGHT`=0 keeps `AN` all 1; `BRIGHT`=9 keeps each anode low for all 4 cycles.
